// File: rtl/aes_pkg.sv
// Shared AES types and GF/byte-permutation helpers for the iterative AES-128 core.
package aes_pkg;

   localparam int unsigned NUM_ROUNDS = 10;
   localparam int unsigned BLOCK_BITS = 128;

   typedef logic [0:BLOCK_BITS-1] block_t;

   typedef enum logic [1:0] {
      IDLE,
      SUB,
      MIX,
      DONE
   } state_e;

   // Forward S-box, entry n at bits [8n +: 8]
   localparam logic [0:2047] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TABLE[{b, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // One state column, first byte in the most significant position
   function automatic logic [31:0] mix_column(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   // Row r rotates left by r columns; byte index is 4*col + row
   function automatic block_t shift_rows(input block_t s);
      block_t o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[7'(32*c + 8*r) +: 8] = s[7'(32*((c + r) % 4) + 8*r) +: 8];
         end
      end
      return o;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single combinational AES forward S-box.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] data_i,
   output logic [7:0] data_o
);

   assign data_o = sbox(data_i);

endmodule

// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryptor with on-the-fly key expansion and valid/ready on both sides.
// Define AES_ROUND_TRACE_EN to add the per-round trace outputs.
module aes128_iter_core
   import aes_pkg::*;
#(
   parameter int unsigned SBOX_LANES = 16
) (
   input  logic                  i_clock,
   input  logic                  i_reset_n,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [0:BLOCK_BITS-1] i_plain,
   input  logic [0:BLOCK_BITS-1] i_key,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [0:BLOCK_BITS-1] o_cipher
`ifdef AES_ROUND_TRACE_EN
   ,
   output logic                  o_trace_valid,
   output logic [3:0]            o_trace_round,
   output logic [0:BLOCK_BITS-1] o_trace_data
`endif
);

   localparam int unsigned SUB_CYCLES = 16 / SBOX_LANES;
   localparam int unsigned LANE_W     = (SUB_CYCLES > 1) ? $clog2(SUB_CYCLES) : 1;
   localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(SUB_CYCLES - 1);

   if (SBOX_LANES != 4 && SBOX_LANES != 8 && SBOX_LANES != 16) begin : g_bad_lanes
      $error("SBOX_LANES must be 4, 8 or 16");
   end

   state_e            fsm_q, fsm_d;
   block_t            st_q, st_d;
   block_t            key_q, key_d;
   block_t            cipher_q, cipher_d;
   logic [3:0]        rnd_q, rnd_d;
   logic [7:0]        rcon_q, rcon_d;
   logic [LANE_W-1:0] lane_q, lane_d;
   logic              ready_q, ready_d;
   logic              valid_q, valid_d;

   logic              accept;
   logic              last_rnd;
   int unsigned       lane_base;
   logic [7:0]        lane_out [SBOX_LANES];
   block_t            sub_state, sr_state, mc_state, round_out, nk;
   logic [0:31]       rot_w, sub_w, temp_w;

   assign accept    = i_valid && ready_q;
   assign last_rnd  = (rnd_q == 4'(NUM_ROUNDS));
   assign lane_base = 32'(lane_q) * SBOX_LANES;

   // SubBytes lanes over the current slice of the state
   for (genvar k = 0; k < SBOX_LANES; k++) begin : g_lane
      logic [7:0] lane_in;
      assign lane_in = st_q[7'(8*(lane_base + k)) +: 8];
      aes_sbox u_sbox (.data_i(lane_in), .data_o(lane_out[k]));
   end

   always_comb begin
      sub_state = st_q;
      for (int k = 0; k < SBOX_LANES; k++) begin
         sub_state[7'(8*(lane_base + 32'(k))) +: 8] = lane_out[k];
      end
   end

   assign sr_state = shift_rows(st_q);
   for (genvar c = 0; c < 4; c++) begin : g_mix
      assign mc_state[32*c +: 32] = mix_column(sr_state[32*c +: 32]);
   end

   // Key schedule: RotWord, SubWord, rcon, then the word chain
   assign rot_w = {key_q[104:127], key_q[96:103]};
   for (genvar j = 0; j < 4; j++) begin : g_ks
      aes_sbox u_ks_sbox (.data_i(rot_w[8*j +: 8]), .data_o(sub_w[8*j +: 8]));
   end
   assign temp_w        = sub_w ^ {rcon_q, 24'h000000};
   assign nk[0:31]      = key_q[0:31]   ^ temp_w;
   assign nk[32:63]     = key_q[32:63]  ^ nk[0:31];
   assign nk[64:95]     = key_q[64:95]  ^ nk[32:63];
   assign nk[96:127]    = key_q[96:127] ^ nk[64:95];

   assign round_out = (last_rnd ? sr_state : mc_state) ^ nk;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) fsm_q <= IDLE;
      else            fsm_q <= fsm_d;
   end

   always_comb begin
      fsm_d = fsm_q;
      unique case (fsm_q)
         IDLE:    if (accept) fsm_d = SUB;
         SUB:     if (lane_q == LANE_LAST) fsm_d = MIX;
         MIX:     fsm_d = last_rnd ? DONE : SUB;
         DONE:    if (i_ready) fsm_d = IDLE;
         default: fsm_d = IDLE;
      endcase
   end

   always_comb begin
      st_d     = st_q;
      key_d    = key_q;
      cipher_d = cipher_q;
      rnd_d    = rnd_q;
      rcon_d   = rcon_q;
      lane_d   = lane_q;
      unique case (fsm_q)
         IDLE: begin
            if (accept) begin
               st_d   = i_plain ^ i_key;
               key_d  = i_key;
               rnd_d  = 4'd1;
               rcon_d = 8'h01;
               lane_d = '0;
            end
         end
         SUB: begin
            st_d = sub_state;
            if (lane_q != LANE_LAST) lane_d = lane_q + LANE_W'(1);
         end
         MIX: begin
            st_d   = round_out;
            key_d  = nk;
            rcon_d = xtime(rcon_q);
            lane_d = '0;
            if (last_rnd) cipher_d = round_out;
            else          rnd_d    = rnd_q + 4'd1;
         end
         default: ;
      endcase
      ready_d = (fsm_d == IDLE);
      valid_d = (fsm_d == DONE);
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         st_q     <= '0;
         key_q    <= '0;
         cipher_q <= '0;
         rnd_q    <= '0;
         rcon_q   <= 8'h01;
         lane_q   <= '0;
         ready_q  <= 1'b1;
         valid_q  <= 1'b0;
      end else begin
         st_q     <= st_d;
         key_q    <= key_d;
         cipher_q <= cipher_d;
         rnd_q    <= rnd_d;
         rcon_q   <= rcon_d;
         lane_q   <= lane_d;
         ready_q  <= ready_d;
         valid_q  <= valid_d;
      end
   end

   assign o_ready  = ready_q;
   assign o_valid  = valid_q;
   assign o_cipher = cipher_q;

`ifdef AES_ROUND_TRACE_EN
   logic       trace_valid_q;
   logic [3:0] trace_round_q;
   block_t     trace_data_q;

   // Post-ARK snapshot of every round, one cycle after its MIX
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         trace_valid_q <= 1'b0;
         trace_round_q <= '0;
         trace_data_q  <= '0;
      end else begin
         trace_valid_q <= (fsm_q == MIX);
         if (fsm_q == MIX) begin
            trace_round_q <= rnd_q;
            trace_data_q  <= round_out;
         end
      end
   end

   assign o_trace_valid = trace_valid_q;
   assign o_trace_round = trace_round_q;
   assign o_trace_data  = trace_data_q;
`endif

endmodule
